// File: rtl/wb_rr_arbiter_2m.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter_2m
//
// Purpose:
//   Lets two Wishbone masters share one Wishbone slave. Masters take turns
//   (round-robin). Once a master owns the bus, it keeps it for its whole CYC.
//   A watchdog ends any strobe that the slave never acknowledges. The
//   offending master receives a one-cycle err pulse, so a hung slave cannot
//   stall the bus.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   m0_* / m1_*                master-side Wishbone ports (adr, dat, we, sel,
//                              stb, cyc in; dat, ack, err out)
//   s_*                        slave-side Wishbone port (adr, dat, we, sel,
//                              stb, cyc out; dat, ack in)
//   grant_o                    one-hot current owner, 2'b00 when idle
// ---------------------------------------------------------------------------
module wb_rr_arbiter_2m #(
    parameter int BUS_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [BUS_WIDTH-1:0]  m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    input  logic                  m0_we_i,
    input  logic [BE_WIDTH-1:0]   m0_sel_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic [BUS_WIDTH-1:0]  m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    input  logic                  m1_we_i,
    input  logic [BE_WIDTH-1:0]   m1_sel_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic [BUS_WIDTH-1:0]  s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic                  s_we_o,
    output logic [BE_WIDTH-1:0]   s_sel_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic                  s_ack_i,

    output logic [1:0]            grant_o
);

    localparam int WDOG_W = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    logic own_cyc;
    logic own_stb;
    logic timeout;

    // Slave-side mux from the current owner. The owner's stb is gated by its
    // own cyc, so slave stb drops in the same cycle that the owner releases
    // the bus. In the watchdog cycle, the strobe is withheld from the slave
    // and any ack is discarded, so err takes priority.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;

        case (state_q)
            GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i & m0_cyc_i;
            end
            GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i & m1_cyc_i;
            end
            default: ;
        endcase

        timeout = own_stb && (wdog_q == WDOG_MAX);
        s_cyc_o = own_cyc;
        s_stb_o = own_stb & ~timeout;

        if (state_q == GNT0) begin
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i & own_stb & ~timeout;
            m0_err_o = timeout;
        end
        if (state_q == GNT1) begin
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i & own_stb & ~timeout;
            m1_err_o = timeout;
        end
    end

    assign grant_o = {state_q == GNT1, state_q == GNT0};

    // Next-state logic. When both masters request while the bus is idle, the
    // master that was not granted last wins. The watchdog counts only the
    // owner's unacknowledged strobe cycles. It returns to zero on an ack, when
    // the strobe is idle, when the bus changes hands, or after it fires.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wdog_d  = '0;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            default: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end else if (own_stb && !timeout && !s_ack_i) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
        endcase
    end

    // After reset, last points at m1, so m0 wins the first contested request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter_2m
//
// Purpose:
//   Self-checking bench for wb_rr_arbiter_2m. A directed sequence of bus
//   scenarios is followed by a randomized phase. Every cycle, each DUT output
//   is compared with a behavioural model of the arbiter. The model tracks
//   three things: who owns the bus, who was granted last, and how many
//   stalled strobe cycles the owner has accumulated.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter_2m;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;

    logic [4:0]  m_adr   [2];
    logic [31:0] m_dat_i [2];
    logic [31:0] m_dat_o [2];
    logic        m_we    [2];
    logic [3:0]  m_sel   [2];
    logic        m_stb   [2];
    logic        m_cyc   [2];
    logic        m_ack   [2];
    logic        m_err   [2];

    logic [4:0]  s_adr;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_we;
    logic [3:0]  s_sel;
    logic        s_stb;
    logic        s_cyc;
    logic        s_ack;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    // Reference model state: -1 means the bus is idle.
    int owner        = -1;
    int last_granted = 1;
    int stall        = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter_2m #(
        .BUS_WIDTH (5),
        .DATA_WIDTH(32),
        .BE_WIDTH  (4),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_adr_i(m_adr[0]),
        .m0_dat_i(m_dat_i[0]),
        .m0_dat_o(m_dat_o[0]),
        .m0_we_i (m_we[0]),
        .m0_sel_i(m_sel[0]),
        .m0_stb_i(m_stb[0]),
        .m0_cyc_i(m_cyc[0]),
        .m0_ack_o(m_ack[0]),
        .m0_err_o(m_err[0]),
        .m1_adr_i(m_adr[1]),
        .m1_dat_i(m_dat_i[1]),
        .m1_dat_o(m_dat_o[1]),
        .m1_we_i (m_we[1]),
        .m1_sel_i(m_sel[1]),
        .m1_stb_i(m_stb[1]),
        .m1_cyc_i(m_cyc[1]),
        .m1_ack_o(m_ack[1]),
        .m1_err_o(m_err[1]),
        .s_adr_o (s_adr),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_we_o  (s_we),
        .s_sel_o (s_sel),
        .s_stb_o (s_stb),
        .s_cyc_o (s_cyc),
        .s_ack_i (s_ack),
        .grant_o (grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from the model's current owner and stall count
    // together with this cycle's inputs.
    task automatic check_output();
        int   o;
        logic oc, os, to;
        if (owner >= 0) begin
            o  = owner;
            oc = m_cyc[o];
            os = m_stb[o] && oc;
            to = os && (stall == TIMEOUT - 1);
            check("s_cyc", 32'(s_cyc), 32'(oc));
            check("s_stb", 32'(s_stb), 32'(os && !to));
            check("s_adr", 32'(s_adr), 32'(m_adr[o]));
            check("s_dat", s_dat_o, m_dat_i[o]);
            check("s_we",  32'(s_we),  32'(m_we[o]));
            check("s_sel", 32'(s_sel), 32'(m_sel[o]));
            check("grant", 32'(grant), (o == 0) ? 32'd1 : 32'd2);
        end else begin
            o = -1;
            check("s_cyc", 32'(s_cyc), 32'd0);
            check("s_stb", 32'(s_stb), 32'd0);
            check("s_adr", 32'(s_adr), 32'd0);
            check("s_dat", s_dat_o, 32'd0);
            check("s_we",  32'(s_we),  32'd0);
            check("s_sel", 32'(s_sel), 32'd0);
            check("grant", 32'(grant), 32'd0);
            os = 1'b0;
            to = 1'b0;
        end
        for (int n = 0; n < 2; n++) begin
            if (n == o) begin
                check($sformatf("m%0d_ack", n), 32'(m_ack[n]), 32'(s_ack && os && !to));
                check($sformatf("m%0d_err", n), 32'(m_err[n]), 32'(to));
                check($sformatf("m%0d_dat", n), m_dat_o[n], s_dat_i);
            end else begin
                check($sformatf("m%0d_ack", n), 32'(m_ack[n]), 32'd0);
                check($sformatf("m%0d_err", n), 32'(m_err[n]), 32'd0);
                check($sformatf("m%0d_dat", n), m_dat_o[n], 32'd0);
            end
        end
    endtask

    // Clock-edge behaviour of the model. Contested idle requests go to the
    // master not granted last. The owner keeps the bus until it drops cyc.
    // The stall count grows on each unacknowledged strobe cycle and clears
    // after a timeout.
    task automatic model_update();
        int o;
        if (reset) begin
            owner        = -1;
            last_granted = 1;
            stall        = 0;
        end else if (owner < 0) begin
            stall = 0;
            if (m_cyc[0] && m_cyc[1]) owner = 1 - last_granted;
            else if (m_cyc[0])        owner = 0;
            else if (m_cyc[1])        owner = 1;
            if (owner >= 0) last_granted = owner;
        end else begin
            o = owner;
            if (!m_cyc[o]) begin
                owner = -1;
                stall = 0;
            end else if (m_stb[o] && !s_ack && stall != TIMEOUT - 1) begin
                stall++;
            end else begin
                stall = 0;
            end
        end
    endtask

    task automatic sample();
        #2;
        check_output();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_stimulus_idle();
        for (int n = 0; n < 2; n++) begin
            m_adr[n]   = '0;
            m_dat_i[n] = '0;
            m_we[n]    = 1'b0;
            m_sel[n]   = '0;
            m_stb[n]   = 1'b0;
            m_cyc[n]   = 1'b0;
        end
        s_ack   = 1'b0;
        s_dat_i = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply_stimulus_idle();
        advance();
        sample();
        advance();
        reset = 1'b0;
    endtask

    initial begin
        int   k;
        logic acked_prev [2];
        logic [1:0] prev_grant;
        int   ack_mode;
        int   err_seen;

        reset = 1'b1;
        apply_stimulus_idle();

        // Scenario 1: single m0 write.
        do_reset();
        sample();
        check("rst_grant", 32'(grant), 32'd0);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 5'h03; m_dat_i[0] = 32'hDEADBEEF; m_sel[0] = 4'hF;
        sample();
        check("t1_grant_lat", 32'(grant), 32'd0);
        advance();
        s_ack = 1'b1;
        sample();
        check("t1_grant", 32'(grant), 32'd1);
        check("t1_s_adr", 32'(s_adr), 32'h03);
        check("t1_s_dat", s_dat_o, 32'hDEADBEEF);
        check("t1_m0_ack", 32'(m_ack[0]), 32'd1);
        check("t1_m1_ack", 32'(m_ack[1]), 32'd0);
        advance();

        // Scenario 2: both masters request together; m0 first, one idle, then m1.
        do_reset();
        for (int n = 0; n < 2; n++) begin m_cyc[n] = 1'b1; m_stb[n] = 1'b1; end
        sample();
        advance();
        s_ack = 1'b1;
        sample();
        check("t2_first", 32'(grant), 32'd1);
        advance();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        sample();
        check("t2_drop_scyc", 32'(s_cyc), 32'd0);
        advance();
        sample();
        check("t2_idle", 32'(grant), 32'd0);
        advance();
        sample();
        check("t2_second", 32'(grant), 32'd2);
        advance();

        // Scenario 3: both keep requesting, each releases cyc right after its ack.
        do_reset();
        acked_prev[0] = 1'b0; acked_prev[1] = 1'b0;
        prev_grant = 2'b00;
        k = 0;
        s_ack = 1'b1;
        for (int c = 0; c < 24; c++) begin
            for (int n = 0; n < 2; n++) begin
                m_cyc[n] = !acked_prev[n];
                m_stb[n] = !acked_prev[n];
            end
            sample();
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                check("t3_alternate", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
                k++;
            end
            prev_grant    = grant;
            acked_prev[0] = m_ack[0];
            acked_prev[1] = m_ack[1];
            advance();
        end
        check("t3_grant_count_ge6", 32'(k >= 6), 32'd1);

        // Scenario 4: m1 stalls on a slave that never acks.
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 5'h0A;
        sample();
        advance();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            sample();
            check($sformatf("t4_err_c%0d", c), 32'(m_err[1]), 32'(c == TIMEOUT));
            check($sformatf("t4_stb_c%0d", c), 32'(s_stb), 32'(c != TIMEOUT));
            check($sformatf("t4_m0err_c%0d", c), 32'(m_err[0]), 32'd0);
            advance();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        sample();
        advance();
        sample();
        advance();
        sample();
        check("t4_m0_after", 32'(grant), 32'd1);
        advance();

        // Scenario 5: reset arrives while m0 is strobing.
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        sample();
        advance();
        sample();
        check("t5_stb_before", 32'(s_stb), 32'd1);
        reset = 1'b1;
        sample();
        advance();
        s_ack = 1'b1;
        sample();
        check("t5_scyc", 32'(s_cyc), 32'd0);
        check("t5_sstb", 32'(s_stb), 32'd0);
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_late_ack", 32'(m_ack[0]), 32'd0);
        advance();
        reset = 1'b0;

        // Scenario 6: m0 read of the top address.
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 5'h1F;
        sample();
        advance();
        s_dat_i = 32'h12345678; s_ack = 1'b1;
        sample();
        check("t6_s_adr", 32'(s_adr), 32'h1F);
        check("t6_m0_dat", m_dat_o[0], 32'h12345678);
        check("t6_m0_ack", 32'(m_ack[0]), 32'd1);
        check("t6_m1_dat", m_dat_o[1], 32'd0);
        advance();

        // Randomized traffic. The slave alternates between responsive phases
        // and silent phases, so the watchdog also fires.
        do_reset();
        err_seen = 0;
        ack_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) ack_mode = 1 - ack_mode;
            reset = ($urandom_range(299) == 0);
            for (int n = 0; n < 2; n++) begin
                if (m_cyc[n]) m_cyc[n] = (ack_mode == 1) ? ($urandom_range(7) != 0)
                                                         : ($urandom_range(63) != 0);
                else          m_cyc[n] = ($urandom_range(3) == 0);
                m_stb[n]   = m_cyc[n] ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
                m_adr[n]   = 5'($urandom);
                m_dat_i[n] = $urandom;
                m_we[n]    = 1'($urandom);
                m_sel[n]   = 4'($urandom);
            end
            s_ack   = (ack_mode == 1) ? 1'($urandom) : ($urandom_range(31) == 0);
            s_dat_i = $urandom;
            sample();
            if (m_err[0] || m_err[1]) err_seen++;
            advance();
        end
        reset = 1'b0;
        $display("[TB] random phase watchdog events: %0d", err_seen);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
